branch_resolve_unit: RTL and testbench

//  Producer side of the branch target buffer update interface. Holds in-order queue of in-flight fetch predictions,

---
 rtl/branch_resolve_unit.sv | 101 ++++++++++
 tb/tb_branch_resolve_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order queue of fetch predictions paired with execute resolutions;
// emits the one-cycle BTB write and a flush/redirect pulse on mispredict.
module branch_resolve_unit #(
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 8,
   parameter int INSTR_BYTES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pred_valid,
   input  logic [ADDR_W-1:0]          pred_pc,
   input  logic                       pred_taken,
   input  logic [ADDR_W-1:0]          pred_target,
   output logic                       pred_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [ADDR_W-1:0]          res_target,
   output logic                       res_ready,
   output logic [ADDR_W-1:0]          wBIA,
   output logic [ADDR_W-1:0]          branchTarget,
   output logic                       PCSrc,
   output logic                       flush,
   output logic [ADDR_W-1:0]          redirect_pc,
   output logic [15:0]                mispredict_count,
   output logic [$clog2(DEPTH):0]     occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   typedef enum logic {RUN, FLUSH} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic [ADDR_W-1:0] tg_mem [DEPTH];
   logic [DEPTH-1:0]  tk_mem;
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [ADDR_W-1:0] wbia_q, wbia_d, btgt_q, btgt_d, redir_q, redir_d;
   logic              pcsrc_q, pcsrc_d, flush_q, flush_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              full, empty, push, pop, mis;
   logic [ADDR_W-1:0] e_pc, e_tg;
   logic              e_tk;
   assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = wr_q == rd_q;
   // Reset also gates the handshakes so nothing is accepted while rst_n is low.
   assign pred_ready = rst_n && state_q == RUN && !full;
   assign res_ready  = rst_n && state_q == RUN && !empty;
   assign push = pred_valid && pred_ready;
   assign pop  = res_valid && res_ready;
   assign e_pc = pc_mem[rd_q[AW-1:0]];
   assign e_tg = tg_mem[rd_q[AW-1:0]];
   assign e_tk = tk_mem[rd_q[AW-1:0]];
   assign mis  = pop && ((e_tk != res_taken) || (e_tk && res_taken && e_tg != res_target));
   always_comb begin
      wr_d    = mis ? '0 : wr_q + PW'(push);
      rd_d    = mis ? '0 : rd_q + PW'(pop);
      state_d = (state_q == RUN && mis) ? FLUSH : RUN;
      pcsrc_d = pop && res_taken;
      flush_d = mis;
      wbia_d  = pop ? e_pc : wbia_q;
      btgt_d  = pop ? res_target : btgt_q;
      redir_d = mis ? (res_taken ? res_target : e_pc + ADDR_W'(INSTR_BYTES)) : redir_q;
      cnt_d   = (mis && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wr_q    <= '0;
         rd_q    <= '0;
         pcsrc_q <= 1'b0;
         flush_q <= 1'b0;
         wbia_q  <= '0;
         btgt_q  <= '0;
         redir_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         pcsrc_q <= pcsrc_d;
         flush_q <= flush_d;
         wbia_q  <= wbia_d;
         btgt_q  <= btgt_d;
         redir_q <= redir_d;
         cnt_q   <= cnt_d;
      end
   end
   // Payload storage needs no reset; pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_q[AW-1:0]] <= pred_pc;
         tg_mem[wr_q[AW-1:0]] <= pred_target;
         tk_mem[wr_q[AW-1:0]] <= pred_taken;
      end
   end
   assign wBIA             = wbia_q;
   assign branchTarget     = btgt_q;
   assign PCSrc            = pcsrc_q;
   assign flush            = flush_q;
   assign redirect_pc      = redir_q;
   assign mispredict_count = cnt_q;
   assign occupancy        = wr_q - rd_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios with hand-computed expectations.
module tb_branch_resolve_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pred_valid = 1'b0, pred_taken = 1'b0, pred_ready;
   logic [15:0] pred_pc = '0, pred_target = '0;
   logic        res_valid = 1'b0, res_taken = 1'b0, res_ready;
   logic [15:0] res_target = '0;
   logic [15:0] wBIA, branchTarget, redirect_pc, mispredict_count;
   logic        PCSrc, flush;
   logic [3:0]  occupancy;
   int pass = 0, total = 0;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .res_ready(res_ready), .wBIA(wBIA), .branchTarget(branchTarget),
      .PCSrc(PCSrc), .flush(flush), .redirect_pc(redirect_pc),
      .mispredict_count(mispredict_count), .occupancy(occupancy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
      pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
      cyc();
      pred_valid = 1'b0;
   endtask

   task automatic resolve(input logic tk, input logic [15:0] tg);
      res_valid = 1'b1; res_taken = tk; res_target = tg;
      cyc();
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (occupancy !== 4'd0) $display("FAIL rst_occ got=%0d exp=0", occupancy); else pass++;
      total++; if (PCSrc !== 1'b0 || flush !== 1'b0) $display("FAIL rst_pulses got=%b%b exp=00", PCSrc, flush); else pass++;
      total++; if (pred_ready !== 1'b0) $display("FAIL rst_pready_low got=%b exp=0", pred_ready); else pass++;
      rst_n = 1'b1;
      cyc();
      total++; if (pred_ready !== 1'b1) $display("FAIL rst_pready got=%b exp=1", pred_ready); else pass++;
      total++; if (res_ready !== 1'b0) $display("FAIL rst_rready got=%b exp=0", res_ready); else pass++;
      push(16'h0A00, 1'b1, 16'h0B00);
      push(16'h0A04, 1'b0, 16'h0000);
      push(16'h0A08, 1'b1, 16'h0C00);
      total++; if (occupancy !== 4'd3) $display("FAIL rst_fill got=%0d exp=3", occupancy); else pass++;
      res_valid = 1'b1; res_taken = 1'b0; res_target = 16'h0;
      rst_n = 1'b0;
      #1;
      total++; if (occupancy !== 4'd0) $display("FAIL rst_mid_occ got=%0d exp=0", occupancy); else pass++;
      total++; if (PCSrc !== 1'b0 || flush !== 1'b0) $display("FAIL rst_mid_pulses got=%b%b exp=00", PCSrc, flush); else pass++;
      cyc();
      res_valid = 1'b0;
      rst_n = 1'b1;
      cyc();
      total++; if (pred_ready !== 1'b1) $display("FAIL rst_mid_pready got=%b exp=1", pred_ready); else pass++;
      total++; if (PCSrc !== 1'b0 || wBIA !== 16'h0) $display("FAIL rst_no_write got=%b/%h exp=0/0000", PCSrc, wBIA); else pass++;
      total++; if (mispredict_count !== 16'd0) $display("FAIL rst_cnt got=%0d exp=0", mispredict_count); else pass++;
   endtask

   task automatic test_empty_resolve();
      resolve(1'b1, 16'h1111);
      total++; if (PCSrc !== 1'b0 || flush !== 1'b0) $display("FAIL empty_res got=%b%b exp=00", PCSrc, flush); else pass++;
      total++; if (occupancy !== 4'd0) $display("FAIL empty_occ got=%0d exp=0", occupancy); else pass++;
   endtask

   task automatic test_correct_taken();
      push(16'h0040, 1'b1, 16'h0100);
      resolve(1'b1, 16'h0100);
      total++; if (PCSrc !== 1'b1) $display("FAIL ct_pcsrc got=%b exp=1", PCSrc); else pass++;
      total++; if (wBIA !== 16'h0040) $display("FAIL ct_wbia got=%h exp=0040", wBIA); else pass++;
      total++; if (branchTarget !== 16'h0100) $display("FAIL ct_tgt got=%h exp=0100", branchTarget); else pass++;
      total++; if (flush !== 1'b0) $display("FAIL ct_flush got=%b exp=0", flush); else pass++;
      total++; if (mispredict_count !== 16'd0) $display("FAIL ct_cnt got=%0d exp=0", mispredict_count); else pass++;
      cyc();
      total++; if (PCSrc !== 1'b0) $display("FAIL ct_pulse got=%b exp=0", PCSrc); else pass++;
      total++; if (wBIA !== 16'h0040) $display("FAIL ct_hold got=%h exp=0040", wBIA); else pass++;
   endtask

   task automatic test_dir_mispredict();
      push(16'h0010, 1'b0, 16'h0000);
      resolve(1'b1, 16'h0080);
      total++; if (PCSrc !== 1'b1 || flush !== 1'b1) $display("FAIL dm_pulses got=%b%b exp=11", PCSrc, flush); else pass++;
      total++; if (redirect_pc !== 16'h0080) $display("FAIL dm_redir got=%h exp=0080", redirect_pc); else pass++;
      total++; if (mispredict_count !== 16'd1) $display("FAIL dm_cnt got=%0d exp=1", mispredict_count); else pass++;
      total++; if (pred_ready !== 1'b0) $display("FAIL dm_pready got=%b exp=0", pred_ready); else pass++;
      cyc();
      total++; if (flush !== 1'b0 || pred_ready !== 1'b1) $display("FAIL dm_recover got=%b%b exp=01", flush, pred_ready); else pass++;
   endtask

   task automatic test_taken_not_taken();
      push(16'hFFFC, 1'b1, 16'h1234);
      resolve(1'b0, 16'h0000);
      total++; if (PCSrc !== 1'b0 || flush !== 1'b1) $display("FAIL tn_pulses got=%b%b exp=01", PCSrc, flush); else pass++;
      total++; if (redirect_pc !== 16'h0000) $display("FAIL tn_redir got=%h exp=0000", redirect_pc); else pass++;
      total++; if (wBIA !== 16'hFFFC) $display("FAIL tn_wbia got=%h exp=fffc", wBIA); else pass++;
      total++; if (mispredict_count !== 16'd2) $display("FAIL tn_cnt got=%0d exp=2", mispredict_count); else pass++;
      cyc();
      push(16'h0020, 1'b1, 16'h0200);
      resolve(1'b1, 16'h0300);
      total++; if (flush !== 1'b1 || redirect_pc !== 16'h0300) $display("FAIL tgt_mis got=%b/%h exp=1/0300", flush, redirect_pc); else pass++;
      total++; if (mispredict_count !== 16'd3) $display("FAIL tgt_cnt got=%0d exp=3", mispredict_count); else pass++;
      cyc();
   endtask

   task automatic test_full_wrap();
      logic [15:0] q[$];
      logic [15:0] pc;
      for (int i = 0; i < 8; i++) begin
         pc = 16'h0100 + 16'(i * 4);
         push(pc, 1'b1, pc + 16'h0010);
         q.push_back(pc);
      end
      total++; if (occupancy !== 4'd8) $display("FAIL full_occ got=%0d exp=8", occupancy); else pass++;
      total++; if (pred_ready !== 1'b0) $display("FAIL full_pready got=%b exp=0", pred_ready); else pass++;
      pred_valid = 1'b1; pred_pc = 16'h0DEA; pred_taken = 1'b1; pred_target = 16'h0BEE;
      resolve(1'b1, 16'h0110);
      pred_valid = 1'b0;
      pc = q.pop_front();
      total++; if (occupancy !== 4'd7) $display("FAIL full_refuse got=%0d exp=7", occupancy); else pass++;
      total++; if (wBIA !== pc) $display("FAIL full_pop0 got=%h exp=%h", wBIA, pc); else pass++;
      while (q.size() > 0) begin
         pc = q.pop_front();
         resolve(1'b1, pc + 16'h0010);
         total++; if (wBIA !== pc || flush !== 1'b0) $display("FAIL drain got=%h/%b exp=%h/0", wBIA, flush, pc); else pass++;
      end
      total++; if (occupancy !== 4'd0) $display("FAIL drain_occ got=%0d exp=0", occupancy); else pass++;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) begin
            pc = 16'h0200 + 16'(r * 64 + i * 4);
            push(pc, 1'b1, pc + 16'h0010);
            q.push_back(pc);
         end
         pc = 16'h0200 + 16'(r * 64 + 16);
         pred_valid = 1'b1; pred_pc = pc; pred_taken = 1'b1; pred_target = pc + 16'h0010;
         q.push_back(pc);
         pc = q.pop_front();
         resolve(1'b1, pc + 16'h0010);
         pred_valid = 1'b0;
         total++; if (occupancy !== 4'd4) $display("FAIL pp_occ got=%0d exp=4", occupancy); else pass++;
         total++; if (wBIA !== pc) $display("FAIL pp_wbia got=%h exp=%h", wBIA, pc); else pass++;
         while (q.size() > 0) begin
            pc = q.pop_front();
            resolve(1'b1, pc + 16'h0010);
            total++; if (wBIA !== pc || PCSrc !== 1'b1) $display("FAIL wrap_order got=%h/%b exp=%h/1", wBIA, PCSrc, pc); else pass++;
         end
      end
      total++; if (mispredict_count !== 16'd3) $display("FAIL wrap_cnt got=%0d exp=3", mispredict_count); else pass++;
   endtask

   task automatic test_flush_discard();
      for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i * 4), 1'b0, 16'h0000);
      total++; if (occupancy !== 4'd4) $display("FAIL fd_fill got=%0d exp=4", occupancy); else pass++;
      pred_valid = 1'b1; pred_pc = 16'h0400; pred_taken = 1'b0; pred_target = 16'h0000;
      resolve(1'b1, 16'h0500);
      pred_valid = 1'b0;
      total++; if (occupancy !== 4'd0) $display("FAIL fd_occ got=%0d exp=0", occupancy); else pass++;
      total++; if (flush !== 1'b1 || redirect_pc !== 16'h0500) $display("FAIL fd_redir got=%b/%h exp=1/0500", flush, redirect_pc); else pass++;
      total++; if (wBIA !== 16'h0300) $display("FAIL fd_wbia got=%h exp=0300", wBIA); else pass++;
      total++; if (res_ready !== 1'b0 || pred_ready !== 1'b0) $display("FAIL fd_ready got=%b%b exp=00", res_ready, pred_ready); else pass++;
      total++; if (mispredict_count !== 16'd4) $display("FAIL fd_cnt got=%0d exp=4", mispredict_count); else pass++;
      cyc();
      total++; if (occupancy !== 4'd0 || res_ready !== 1'b0) $display("FAIL fd_dropped got=%0d/%b exp=0/0", occupancy, res_ready); else pass++;
      total++; if (pred_ready !== 1'b1 || flush !== 1'b0) $display("FAIL fd_run got=%b%b exp=10", pred_ready, flush); else pass++;
   endtask

   initial begin
      #2;
      test_reset();
      test_empty_resolve();
      test_correct_taken();
      test_dir_mispredict();
      test_taken_not_taken();
      test_full_wrap();
      test_flush_discard();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
